// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - fixed-latency word-addressed data SRAM responder for the core's data port.
// Optional single-entry last-read buffer enabled by `define DSRAM_LASTHIT_EN.
module dsram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  input  logic        pipe_stall,
  output logic [31:0] sram_rdata,
  output logic        d_stall,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [0:DEPTH-1];

  logic [ADDR_W-1:0] req_idx;
  logic              access;
  logic              hit;

  assign req_idx = sram_addr[ADDR_W+1:2];
  assign access  = (state == BUSY) && (cnt == 4'd0);

`ifdef DSRAM_LASTHIT_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_idx;
  logic [31:0]       buf_data;

  // Only reads may hit; writes always take the full path so they land in memory.
  assign hit = (state == IDLE) && sram_en && (sram_wen == 4'b0000) &&
               buf_valid && (buf_idx == req_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if (access) begin
      if (wen_q == 4'b0000) begin
        buf_valid <= 1'b1;
        buf_idx   <= idx_q;
        buf_data  <= mem[idx_q];
      end else if (buf_valid && (buf_idx == idx_q)) begin
        for (int i = 0; i < 4; i++) begin
          if (wen_q[i]) buf_data[8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign sram_rdata = hit ? buf_data : rdata_q;
`else
  assign hit        = 1'b0;
  assign sram_rdata = rdata_q;
`endif

  assign d_stall = ((state == IDLE) && sram_en && !hit) || (state == BUSY);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sram_en && !hit) begin
            idx_q   <= req_idx;
            wen_q   <= sram_wen;
            wdata_q <= sram_wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Captured before the lane writes below take effect.
            rdata_q <= mem[idx_q];
            state   <= DONE;
          end
        end
        DONE: begin
          if (!pipe_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory array is intentionally not reset; a write only happens on the single access cycle.
  always_ff @(posedge clk) begin
    if (access) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
